// File: rtl/cba_pkg.sv
// Shared definitions for the pipelined carry-bypass adder.
//   num_stages()  : pipe depth derived from WIDTH / (GROUP * GROUPS_PER_STAGE)
//   width_legal() : true when WIDTH splits evenly into whole pipe stages
//   cba_stage_ctl_t : per-stage control fields of the stage record
package cba_pkg;

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned group,
                                             input int unsigned gps);
    if ((group * gps) == 0) return 0;
    return width / (group * gps);
  endfunction

  function automatic bit width_legal(input int unsigned width,
                                     input int unsigned group,
                                     input int unsigned gps);
    if (width == 0 || group == 0 || gps == 0) return 1'b0;
    return (width % (group * gps)) == 0;
  endfunction

  // valid : beat present in this bank
  // carry : carry leaving the highest bit resolved so far
  // ovf   : signed overflow of the prefix resolved so far (final in last bank)
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } cba_stage_ctl_t;

endpackage

// File: rtl/pipelined_carry_bypass_adder_if.sv
// Stream interface of the pipelined carry-bypass adder.
//   in_valid/in_ready   : operand beat handshake (in1, in2, c_in, sub)
//   out_valid/out_ready : result handshake (sum, c_out, overflow)
//   master : producer/consumer side (testbench, upstream logic)
//   slave  : the adder itself
interface pipelined_carry_bypass_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, in1, in2, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, in1, in2, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/cba_group.sv
// One carry-bypass group: GROUP-bit ripple adder with a bypass mux on the
// carry output.
//   a, b : group operand bits
//   cin  : carry into the group
//   s    : group sum bits
//   cout : carry out; taken straight from cin when every bit propagates
module cba_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout
);
  logic [GROUP:0] c;
  logic           p;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    p    = &(a ^ b);
    cout = p ? cin : c[GROUP];
  end
endmodule

// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor with a valid/ready stream.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of pipelined_carry_bypass_adder_if
//                (in1/in2/c_in/sub in, sum/c_out/overflow out)
// Each pipe stage resolves GROUP*GROUPS_PER_STAGE bits through a chain of
// bypass groups and registers one bank. sum = A+B+c_in or A-B-c_in mod 2^WIDTH.
module pipelined_carry_bypass_adder
  import cba_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned GROUP            = 4,
  parameter int unsigned GROUPS_PER_STAGE = 2
) (
  input logic                           clk,
  input logic                           rst_n,
  pipelined_carry_bypass_adder_if.slave bus
);
  localparam int unsigned SEG      = GROUP * GROUPS_PER_STAGE;
  localparam bit          WIDTH_OK = width_legal(WIDTH, GROUP, GROUPS_PER_STAGE);
  localparam int unsigned STAGES   = num_stages(WIDTH, GROUP, GROUPS_PER_STAGE);

  if (!WIDTH_OK) begin : g_width_check
    $error("WIDTH must be a non-zero multiple of GROUP*GROUPS_PER_STAGE");
  end

  // Operands travel shifted right by SEG per stage so the next unresolved
  // segment always sits at bit 0. The sum fills in from the top: each stage
  // shifts the partial sum down and inserts its segment at the MSB end, so
  // after STAGES banks it is fully aligned.
  typedef struct packed {
    cba_stage_ctl_t   ctl;
    logic [WIDTH-1:0] sum_part;
    logic [WIDTH-1:0] a_rest;
    logic [WIDTH-1:0] b_rest;
  } stage_t;

  stage_t           stage_q [STAGES];
  stage_t           stage_d [STAGES];
  logic             adv;
  logic [WIDTH-1:0] b_prep;
  logic             cin_prep;

  // Subtraction as A + ~B + ~borrow_in; c_out then reads as "no borrow".
  always_comb begin
    b_prep   = bus.sub ? ~bus.in2 : bus.in2;
    cin_prep = bus.sub ? ~bus.c_in : bus.c_in;
  end

  // Single global enable: the whole pipe moves unless a finished result is
  // waiting on downstream. Bubbles move like beats.
  assign adv = !stage_q[STAGES-1].ctl.valid || bus.out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             src_valid;
    logic             src_cin;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [SEG-1:0]   seg_s;
    logic [WIDTH-1:0] seg_wide;
    logic             seg_cout;
    logic             msb_cin;

    if (s == 0) begin : g_src
      assign src_valid = bus.in_valid;
      assign src_cin   = cin_prep;
      assign src_a     = bus.in1;
      assign src_b     = b_prep;
      assign src_sum   = '0;
    end else begin : g_src
      assign src_valid = stage_q[s-1].ctl.valid;
      assign src_cin   = stage_q[s-1].ctl.carry;
      assign src_a     = stage_q[s-1].a_rest;
      assign src_b     = stage_q[s-1].b_rest;
      assign src_sum   = stage_q[s-1].sum_part;
    end

    for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
      logic cin_g;
      logic cout_g;

      if (g == 0) begin : g_cin
        assign cin_g = src_cin;
      end else begin : g_cin
        assign cin_g = g_grp[g-1].cout_g;
      end

      cba_group #(
        .GROUP(GROUP)
      ) u_group (
        .a   (src_a[g*GROUP +: GROUP]),
        .b   (src_b[g*GROUP +: GROUP]),
        .cin (cin_g),
        .s   (seg_s[g*GROUP +: GROUP]),
        .cout(cout_g)
      );
    end

    assign seg_cout = g_grp[GROUPS_PER_STAGE-1].cout_g;
    // Carry into the segment MSB recovered from its sum bit and operand bits.
    assign msb_cin  = seg_s[SEG-1] ^ src_a[SEG-1] ^ src_b[SEG-1];

    always_comb begin
      seg_wide            = '0;
      seg_wide[SEG-1:0]   = seg_s;
      stage_d[s]          = stage_q[s];
      if (adv) begin
        stage_d[s].ctl.valid = src_valid;
        stage_d[s].ctl.carry = seg_cout;
        stage_d[s].ctl.ovf   = msb_cin ^ seg_cout;
        stage_d[s].sum_part  = (src_sum >> SEG) | (seg_wide << (WIDTH - SEG));
        stage_d[s].a_rest    = src_a >> SEG;
        stage_d[s].b_rest    = src_b >> SEG;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[s] <= '0;
      end else begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = stage_q[STAGES-1].ctl.valid;
  assign bus.sum       = stage_q[STAGES-1].sum_part;
  assign bus.c_out     = stage_q[STAGES-1].ctl.carry;
  assign bus.overflow  = stage_q[STAGES-1].ctl.ovf;

endmodule
